excess3_to_bcd_packer: RTL and testbench

EXCESS3_TO_BCD_PACKER -- requirements
Module: excess3_to_bcd_packer

---
 rtl/excess3_to_bcd_packer.sv | 83 ++++++++
 tb/tb_excess3_to_bcd_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_to_bcd_packer.sv
// Packs a stream of Excess-3 digits (MSD first) into a right-aligned BCD word.
// A frame closes after NDIG digits or on in_last, then holds until the consumer takes it.
module excess3_to_bcd_packer #(
  parameter int NDIG = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  in_x3,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*NDIG-1:0]           out_bcd,
  output logic                        out_err,
  output logic [$clog2(NDIG+1)-1:0]   out_ndig
);

  localparam int CW = $clog2(NDIG+1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state, state_n;
  logic [4*NDIG-1:0] acc, acc_n;
  logic              err, err_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              accept;
  logic              code_ok;
  logic [3:0]        d;

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    err_n     = err;
    cnt_n     = cnt;
    in_ready  = (state == COLLECT);
    out_valid = (state == HOLD);
    accept    = in_valid && (state == COLLECT);
    code_ok   = (in_x3 >= 4'h3) && (in_x3 <= 4'hC);
    d         = code_ok ? (in_x3 - 4'h3) : 4'h0;

    case (state)
      COLLECT: begin
        if (accept) begin
          // Shift left one nibble; for NDIG=1 the shift empties the word.
          acc_n = (acc << 4) | (4*NDIG)'(d);
          err_n = err | ~code_ok;
          cnt_n = cnt + CW'(1);
          if (in_last || (cnt_n == CW'(NDIG)))
            state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = COLLECT;
          acc_n   = '0;
          err_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
      acc   <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      err   <= err_n;
      cnt   <= cnt_n;
    end
  end

  assign out_bcd  = acc;
  assign out_err  = err;
  assign out_ndig = cnt;

endmodule

// File: tb/tb_excess3_to_bcd_packer.sv
// Scoreboard bench for excess3_to_bcd_packer: frames are modelled arithmetically,
// expected words queued at frame close and compared when the DUT hands a word off.
module tb_excess3_to_bcd_packer;

  localparam int NDIG = 4;
  localparam int CW   = $clog2(NDIG+1);

  typedef struct {
    logic [4*NDIG-1:0] bcd;
    logic              err;
    int                ndig;
  } word_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [3:0]          in_x3 = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [4*NDIG-1:0]   out_bcd;
  logic                out_err;
  logic [CW-1:0]       out_ndig;

  int checks = 0;
  int failures = 0;

  word_t exp_q[$];

  // frame reference state
  longint fr_val = 0;
  bit     fr_err = 0;
  int     fr_cnt = 0;

  bit rand_ordy = 0;

  excess3_to_bcd_packer #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x3(in_x3), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_err(out_err), .out_ndig(out_ndig)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one code until accepted; update the frame model on acceptance.
  task automatic send(input logic [3:0] code, input bit last);
    bit acc_ok = 0;
    bit rdy;
    bit close;
    int waits = 0;
    in_valid = 1'b1;
    in_x3    = code;
    in_last  = last;
    while (!acc_ok && waits < 200) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) acc_ok = 1;
      waits++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc_ok) begin
      check("accept_timeout", 0, 1);
      return;
    end
    fr_cnt++;
    if (code >= 4'h3 && code <= 4'hC) fr_val = fr_val * 16 + (code - 3);
    else begin
      fr_val = fr_val * 16;
      fr_err = 1;
    end
    close = last || (fr_cnt == NDIG);
    if (close) begin
      exp_q.push_back('{bcd: fr_val[4*NDIG-1:0], err: fr_err, ndig: fr_cnt});
      fr_val = 0; fr_err = 0; fr_cnt = 0;
    end
    check("latency_out_valid", out_valid, close);
  endtask

  task automatic send_frame(input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3, input int n);
    logic [3:0] codes[4];
    codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
    for (int i = 0; i < n; i++) send(codes[i], (i == n-1) && (n < NDIG));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fr_val = 0; fr_err = 0; fr_cnt = 0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_bcd"}, out_bcd, 0);
    check({tag, "_out_err"}, out_err, 0);
    check({tag, "_out_ndig"}, out_ndig, 0);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: handshakes, hold stability and ready/valid exclusivity.
  logic              prev_valid = 0;
  logic              prev_hs = 0;
  logic [4*NDIG-1:0] prev_bcd;
  logic              prev_err;
  logic [CW-1:0]     prev_ndig;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      check("in_ready_vs_out_valid", in_ready, !out_valid);
      if (prev_valid && !prev_hs) begin
        check("hold_valid", out_valid, 1);
        check("hold_bcd", out_bcd, prev_bcd);
        check("hold_err", out_err, prev_err);
        check("hold_ndig", out_ndig, prev_ndig);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("out_bcd", out_bcd, e.bcd);
          check("out_err", out_err, e.err);
          check("out_ndig", out_ndig, e.ndig);
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_bcd   = out_bcd;
      prev_err   = out_err;
      prev_ndig  = out_ndig;
    end
  end

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_idle("reset");

    // full frame, expected 0x1479
    send_frame(4'h4, 4'h7, 4'hA, 4'hC, 4);
    check("full_bcd_const", out_bcd, 16'h1479);
    check("full_ndig_const", out_ndig, 4);
    drain();

    // short frame, expected 0x0025
    send_frame(4'h5, 4'h8, 4'h0, 4'h0, 2);
    check("short_bcd_const", out_bcd, 16'h0025);
    drain();

    // invalid code inside a frame, expected 0x3008 with error
    send_frame(4'h6, 4'hF, 4'h3, 4'hB, 4);
    check("invalid_bcd_const", out_bcd, 16'h3008);
    check("invalid_err_const", out_err, 1);
    drain();

    // boundary codes
    send_frame(4'h3, 4'hC, 4'h0, 4'h0, 2);
    check("boundary_valid_bcd", out_bcd, 16'h0009);
    check("boundary_valid_err", out_err, 0);
    drain();
    send_frame(4'h2, 4'h0, 4'h0, 4'h0, 1);
    check("boundary_0x2_err", out_err, 1);
    drain();
    send_frame(4'hD, 4'h0, 4'h0, 4'h0, 1);
    check("boundary_0xD_err", out_err, 1);
    drain();

    // in_last on the NDIG-th digit
    for (int i = 0; i < NDIG; i++) send(4'h3 + 4'(i), i == NDIG-1);
    drain();

    // backpressure with in_valid held high
    out_ready = 1'b0;
    send_frame(4'h9, 4'h8, 4'h7, 4'h6, 4);
    in_valid = 1'b1;
    in_x3 = 4'h5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", in_ready, 1);
    send_frame(4'h5, 4'h4, 4'h0, 4'h0, 2);
    drain();

    // reset mid-frame discards partial data
    send(4'hB, 0);
    send(4'hE, 0);
    do_reset();
    check_idle("midreset");
    send_frame(4'h3, 4'h4, 4'h5, 4'h6, 4);
    check("midreset_bcd_const", out_bcd, 16'h0123);
    check("midreset_err_const", out_err, 0);
    drain();

    // reset while a word is held
    out_ready = 1'b0;
    send_frame(4'h7, 4'h7, 4'h0, 4'h0, 2);
    do_reset();
    out_ready = 1'b1;
    check_idle("holdreset");

    // randomized frames with gaps and random backpressure
    rand_ordy = 1;
    for (int f = 0; f < 300; f++) begin
      int n;
      n = $urandom_range(1, NDIG);
      for (int i = 0; i < n; i++) begin
        logic [3:0] c;
        if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
        else c = 4'($urandom_range(3, 12));
        if ($urandom_range(0, 2) == 0) begin
          int g;
          g = $urandom_range(1, 3);
          for (int k = 0; k < g; k++) tick();
        end
        send(c, (i == n-1) && (n < NDIG || $urandom_range(0, 1) == 1));
      end
    end
    rand_ordy = 0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
